row_scanout: RTL

//  Downstream consumer of the row drawer: owns the ping-pong row buffer and VGA timing.

---
 rtl/row_scanout.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/row_scanout.sv
// VGA scan-out of the displayed half of a ping-pong row buffer: reads, colours and
// clears each pixel behind the beam, and hands the other bank to the drawer once per row.
module row_scanout #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          ROW_W      = 480,
  parameter int          X_OFFSET   = 80,
  parameter logic [23:0] BORDER_RGB = 24'h202020,
  parameter logic [23:0] BG_RGB     = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [8:0]  address_read_row,
  input  logic [23:0] data_read_row,
  output logic [8:0]  address_clear_row,
  output logic        wren_clear,
  output logic        bank_sel,
  output logic        swap,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Stage 0: raster counters and everything derived combinationally from them
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_last;
  logic       v_last;
  logic       s0_de;
  logic       s0_hs;
  logic       s0_vs;
  logic       s0_fs;
  logic       s0_in_win;

  assign h_last = (h_cnt == 10'(H_TOTAL - 1));
  assign v_last = (v_cnt == 10'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign s0_de     = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  assign s0_hs     = !((h_cnt >= 10'(H_ACTIVE + H_FP)) &&
                       (h_cnt <  10'(H_ACTIVE + H_FP + H_SYNC)));
  assign s0_vs     = !((v_cnt >= 10'(V_ACTIVE + V_FP)) &&
                       (v_cnt <  10'(V_ACTIVE + V_FP + V_SYNC)));
  assign s0_fs     = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign s0_in_win = (v_cnt < 10'(V_ACTIVE)) &&
                     (h_cnt >= 10'(X_OFFSET)) &&
                     (h_cnt <  10'(X_OFFSET + ROW_W));

  assign address_read_row = s0_in_win ? 9'(h_cnt - 10'(X_OFFSET)) : 9'd0;

  // Last line of the frame preloads row 0; visible line k preloads row k+1
  assign swap = h_last && (v_last || (v_cnt < 10'(V_ACTIVE - 1)));

  // The flip lands on the same edge as h_cnt -> 0, so the drawer gets a full line
  always_ff @(posedge clk) begin
    if (reset) bank_sel <= 1'b0;
    else if (swap) bank_sel <= ~bank_sel;
  end

  // Stage 1: read data arrives; the pixel just read is cleared in the same bank.
  // The last in-window clear happens at h = X_OFFSET+ROW_W, long before the bank
  // flips at the line wrap, so the live bank_sel is always the bank it was read from.
  logic       s1_de;
  logic       s1_hs;
  logic       s1_vs;
  logic       s1_fs;
  logic       s1_in_win;
  logic [8:0] s1_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_de     <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      s1_fs     <= 1'b0;
      s1_in_win <= 1'b0;
      s1_addr   <= '0;
    end else begin
      s1_de     <= s0_de;
      s1_hs     <= s0_hs;
      s1_vs     <= s0_vs;
      s1_fs     <= s0_fs;
      s1_in_win <= s0_in_win;
      s1_addr   <= address_read_row;
    end
  end

  assign wren_clear        = s1_in_win;
  assign address_clear_row = s1_addr;

  // Stage 2: colour selection and registered pins
  logic [23:0] pix_next;
  logic [23:0] rgb;

  always_comb begin
    pix_next = '0;
    if (s1_de) begin
      if (!s1_in_win)                pix_next = BORDER_RGB;
      else if (data_read_row == '0)  pix_next = BG_RGB;
      else                           pix_next = data_read_row;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb         <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_de      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rgb         <= pix_next;
      vga_hs      <= s1_hs;
      vga_vs      <= s1_vs;
      vga_de      <= s1_de;
      frame_start <= s1_fs;
    end
  end

  assign vga_r = rgb[23:16];
  assign vga_g = rgb[15:8];
  assign vga_b = rgb[7:0];

endmodule
